// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared coordinate widths and scheduler state encoding.
// Revision    : 1.0
// ============================================================================
package conv_pkg;

    localparam int COORD_W  = 8;
    localparam int HALF_W   = 2;
    localparam int STRIDE_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; priority starts one past
//               the previous winner and wraps modulo N.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     request_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N-1:0]     grant_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(last_grant_i) + k) % N);
            if (!found && request_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/position_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : position_scheduler
// Description : Walks filter-window centres over an image in row-major order
//               and hands each one to a free window allocator.
// Revision    : 1.0
// ============================================================================
module position_scheduler
    import conv_pkg::*;
#(
    parameter int num_allocators = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [COORD_W-1:0]        image_dim,
    input  logic [HALF_W-1:0]         filter_halfsize,
    input  logic [STRIDE_W-1:0]       filter_stride,
    input  logic [num_allocators-1:0] alloc_release,
    output logic [COORD_W-1:0]        positioner_x,
    output logic [COORD_W-1:0]        positioner_y,
    output logic [num_allocators-1:0] positioner_select,
    output logic [num_allocators-1:0] alloc_busy,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int IDX_W = (num_allocators > 1) ? $clog2(num_allocators) : 1;
    localparam int PW    = COORD_W + 1;

    sched_state_e              state_q;
    logic [COORD_W-1:0]        dim_q;
    logic [HALF_W-1:0]         half_q;
    logic [STRIDE_W-1:0]       stride_q;
    logic [COORD_W-1:0]        x_q;
    logic [COORD_W-1:0]        y_q;
    logic [IDX_W-1:0]          last_grant_q;
    logic [COORD_W-1:0]        pos_x_q;
    logic [COORD_W-1:0]        pos_y_q;
    logic [num_allocators-1:0] sel_q;
    logic [num_allocators-1:0] alloc_busy_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      cfg_err_q;

    logic [num_allocators-1:0] w_free;
    logic [num_allocators-1:0] w_grant;
    logic [IDX_W-1:0]          w_grant_idx;
    logic [PW-1:0]             w_lim;
    logic [PW-1:0]             w_x_next;
    logic [PW-1:0]             w_y_next;
    logic                      w_cfg_bad;

    assign w_free = ~alloc_busy_q;

    rr_arbiter #(
        .N     (num_allocators),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .request_i    (w_free),
        .last_grant_i (last_grant_q),
        .grant_o      (w_grant)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < num_allocators; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = IDX_W'(i);
            end
        end
    end

    // Nine-bit sums keep a step past 255 from aliasing back into range.
    assign w_lim     = PW'(dim_q) - PW'(1) - PW'(half_q);
    assign w_x_next  = PW'(x_q) + PW'(stride_q);
    assign w_y_next  = PW'(y_q) + PW'(stride_q);
    assign w_cfg_bad = (filter_stride == '0) ||
                       (PW'(image_dim) < ((PW'(filter_halfsize) << 1) + PW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dim_q        <= '0;
            half_q       <= '0;
            stride_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            last_grant_q <= IDX_W'(num_allocators - 1);
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            sel_q        <= '0;
            alloc_busy_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            sel_q        <= '0;
            done_q       <= 1'b0;
            alloc_busy_q <= alloc_busy_q & ~alloc_release;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dim_q     <= image_dim;
                        half_q    <= filter_halfsize;
                        stride_q  <= filter_stride;
                        x_q       <= COORD_W'(filter_halfsize);
                        y_q       <= COORD_W'(filter_halfsize);
                        busy_q    <= 1'b1;
                        cfg_err_q <= w_cfg_bad;
                        state_q   <= w_cfg_bad ? FIN : SCAN;
                    end
                end
                SCAN: begin
                    if (|w_free) begin
                        sel_q        <= w_grant;
                        alloc_busy_q <= (alloc_busy_q & ~alloc_release) | w_grant;
                        pos_x_q      <= x_q;
                        pos_y_q      <= y_q;
                        last_grant_q <= w_grant_idx;
                        if (w_x_next <= w_lim) begin
                            x_q <= w_x_next[COORD_W-1:0];
                        end else begin
                            x_q <= COORD_W'(half_q);
                            if (w_y_next <= w_lim) begin
                                y_q <= w_y_next[COORD_W-1:0];
                            end else begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (alloc_busy_q == '0) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign positioner_x      = pos_x_q;
    assign positioner_y      = pos_y_q;
    assign positioner_select = sel_q;
    assign alloc_busy        = alloc_busy_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign cfg_err           = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_position_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_position_scheduler
// Description : Randomised-release bench for position_scheduler against a
//               centre-list and allocator-occupancy reference model.
// Revision    : 1.0
// ============================================================================
module tb_position_scheduler;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   image_dim = '0;
    logic [1:0]   filter_halfsize = '0;
    logic [2:0]   filter_stride = '0;
    logic [N-1:0] alloc_release = '0;
    logic [7:0]   positioner_x;
    logic [7:0]   positioner_y;
    logic [N-1:0] positioner_select;
    logic [N-1:0] alloc_busy;
    logic         busy;
    logic         done;
    logic         cfg_err;

    position_scheduler #(.num_allocators(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .image_dim         (image_dim),
        .filter_halfsize   (filter_halfsize),
        .filter_stride     (filter_stride),
        .alloc_release     (alloc_release),
        .positioner_x      (positioner_x),
        .positioner_y      (positioner_y),
        .positioner_select (positioner_select),
        .alloc_busy        (alloc_busy),
        .busy              (busy),
        .done              (done),
        .cfg_err           (cfg_err)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    logic [N-1:0] b_m = '0;
    int           last_m = N - 1;
    int           phase = 0;    // 0 idle, 1 scanning, 2 draining, 3 finishing
    int           ci = 0;
    int           grants = 0;
    bit           cfg_m = 1'b0;
    int           cx[$];
    int           cy[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build(input int dim, input int h, input int s);
        cx.delete();
        cy.delete();
        for (int y = h; y <= dim - 1 - h; y += s) begin
            for (int x = h; x <= dim - 1 - h; x += s) begin
                cx.push_back(x);
                cy.push_back(y);
            end
        end
    endtask

    function automatic logic [N-1:0] rand_rel();
        logic [N-1:0] r;
        r = b_m & N'($urandom) & N'($urandom);
        if ($urandom_range(0, 5) == 0) r = r | (~b_m & N'($urandom));
        return r;
    endfunction

    // One clock: drive, let the edge happen, predict and compare.
    task automatic step(input logic [N-1:0] rel, input bit st, input int dim, input int h, input int s);
        logic [N-1:0] free;
        logic [N-1:0] exp_sel;
        bit           exp_done;
        int           ex, ey, a;
        alloc_release = rel;
        start         = st;
        if (st) begin
            image_dim = 8'(dim); filter_halfsize = 2'(h); filter_stride = 3'(s);
        end else begin
            image_dim = 8'($urandom); filter_halfsize = 2'($urandom); filter_stride = 3'($urandom);
        end
        @(posedge clk);
        #1;
        exp_sel = '0; exp_done = 1'b0; ex = 0; ey = 0;
        case (phase)
            0: if (st) begin
                cfg_m  = (s == 0) || (dim < 2 * h + 1);
                grants = 0;
                ci     = 0;
                if (cfg_m) phase = 3;
                else begin build(dim, h, s); phase = 1; end
            end
            1: begin
                free = ~b_m;
                if (free != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        a = (last_m + k) % N;
                        if (exp_sel == '0 && free[a]) begin
                            exp_sel[a] = 1'b1;
                            last_m     = a;
                        end
                    end
                    ex = cx[ci]; ey = cy[ci];
                    ci++; grants++;
                    if (ci == cx.size()) phase = 2;
                end
            end
            2: if (b_m == '0) phase = 3;
            3: begin exp_done = 1'b1; phase = 0; end
            default: phase = 0;
        endcase
        b_m = (b_m & ~rel) | exp_sel;
        chk("select", 32'(positioner_select), 32'(exp_sel));
        chk("alloc_busy", 32'(alloc_busy), 32'(b_m));
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(phase != 0));
        chk("cfg_err", 32'(cfg_err), 32'(cfg_m));
        if (exp_sel != '0) begin
            chk("grant_x", 32'(positioner_x), 32'(ex));
            chk("grant_y", 32'(positioner_y), 32'(ey));
        end
        alloc_release = '0;
        start         = 1'b0;
    endtask

    task automatic start_image(input int dim, input int h, input int s);
        step(rand_rel(), 1'b1, dim, h, s);
    endtask

    task automatic finish_image(input int mode);
        int cyc;
        cyc = 0;
        while (phase != 0 && cyc < 20000) begin
            step(rand_rel(), (mode == 1) && ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 7));
            cyc++;
        end
        chk("image_finished", 32'(phase), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x"}, 32'(positioner_x), 32'd0);
        chk({tag, "_y"}, 32'(positioner_y), 32'd0);
        chk({tag, "_select"}, 32'(positioner_select), 32'd0);
        chk({tag, "_alloc_busy"}, 32'(alloc_busy), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step(rand_rel(), 1'b0, 0, 0, 0);

        // Full 6x6 image with random releases.
        start_image(26, 2, 4);
        finish_image(0);
        chk("s1_grants", 32'(grants), 32'd36);

        // Stall with no releases, then free allocator 1.
        start_image(26, 2, 4);
        repeat (8) step('0, 1'b0, 0, 0, 0);
        chk("s2_stall_grants", 32'(grants), 32'd2);
        step(2'b10, 1'b0, 0, 0, 0);
        step('0, 1'b0, 0, 0, 0);
        chk("s2_resume_select", 32'(positioner_select), 32'b10);
        chk("s2_resume_x", 32'(positioner_x), 32'd10);
        finish_image(0);

        // Bad configurations and the smallest valid image.
        start_image(4, 2, 1);
        finish_image(0);
        chk("s3_bad_grants", 32'(grants), 32'd0);
        repeat (3) step(rand_rel(), 1'b0, 0, 0, 0);
        start_image(5, 2, 0);
        finish_image(0);
        start_image(5, 2, 1);
        finish_image(0);
        chk("s3_single_grants", 32'(grants), 32'd1);

        // Asynchronous reset mid-scan, then restart.
        start_image(26, 2, 4);
        for (int c = 0; c < 200 && grants < 5; c++) step(rand_rel(), 1'b0, 0, 0, 0);
        chk("s4_reached_5", 32'(grants), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        b_m = '0; last_m = N - 1; phase = 0; cfg_m = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_image(26, 2, 4);
        finish_image(0);
        chk("s4_restart_grants", 32'(grants), 32'd36);

        // Stray starts during the scan must be ignored.
        start_image(26, 2, 4);
        finish_image(1);
        chk("s5_grants", 32'(grants), 32'd36);

        // Largest image: stepping past 252 must not wrap into range.
        start_image(255, 0, 7);
        finish_image(0);
        chk("s6_grants", 32'(grants), 32'd1369);

        // Random configurations, valid and invalid.
        repeat (6) begin
            start_image($urandom_range(0, 40), $urandom_range(0, 3), $urandom_range(0, 7));
            finish_image(1);
            repeat (2) step(rand_rel(), 1'b0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
